// File: rtl/apu_nn_responder_pkg.sv
// Shared definitions for the APU-side mul/div responder: opcodes, flag indices,
// divider FSM states and the per-stage record of the mul/mac pipeline.
package apu_nn_responder_pkg;

   localparam logic [2:0] APU_OP_MUL  = 3'd0;
   localparam logic [2:0] APU_OP_MULH = 3'd1;
   localparam logic [2:0] APU_OP_MAC  = 3'd2;
   localparam logic [2:0] APU_OP_DIV  = 3'd3;
   localparam logic [2:0] APU_OP_REM  = 3'd4;

   localparam int FLAG_DIVZ = 0;
   localparam int FLAG_ILL  = 1;
   localparam int DIV_STEPS = 32;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] result;
      logic [1:0]  flags;
   } pipe_stage_t;

   // Magnitude of a 32-bit value, treating it as two's complement only when sgn is set.
   function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
      return (sgn && x[31]) ? (~x + 32'd1) : x;
   endfunction

endpackage

// File: rtl/apu_nn_responder_if.sv
// Shared-APU request/grant/rvalid bus between the core (master) and the responder (slave).
interface apu_nn_responder_if #(
   parameter int WOP      = 3,
   parameter int NARGS    = 3,
   parameter int NDSFLAGS = 1,
   parameter int NUSFLAGS = 2
);
   // req holds with a stable payload until req && gnt on a rising edge transfers it;
   // rvalid is a one-cycle strobe per transfer, in transfer order, with no back-pressure.
   logic                  req;
   logic                  gnt;
   logic [NARGS*32-1:0]   operands;
   logic [WOP-1:0]        op;
   logic [NDSFLAGS-1:0]   flags_in;
   logic                  rvalid;
   logic [31:0]           result;
   logic [NUSFLAGS-1:0]   flags_out;

   modport master (
      output req, operands, op, flags_in,
      input  gnt, rvalid, result, flags_out
   );

   modport slave (
      input  req, operands, op, flags_in,
      output gnt, rvalid, result, flags_out
   );
endinterface

// File: rtl/apu_nn_serdiv.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, 32 steps after start.
module apu_nn_serdiv
   import apu_nn_responder_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   output logic        last_o,
   output logic [31:0] quotient_o,
   output logic [31:0] remainder_o
);

   logic [31:0] quo_q, quo_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] dvs_q, dvs_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic [32:0] shifted;
   logic        fits;

   // The quotient register starts as the dividend and shifts its bits into the remainder.
   assign shifted = {rem_q, quo_q[31]};
   assign fits    = (shifted >= {1'b0, dvs_q});

   always_comb begin
      quo_d  = quo_q;
      rem_d  = rem_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (start_i) begin
         quo_d  = dividend_i;
         rem_d  = 32'd0;
         dvs_d  = divisor_i;
         cnt_d  = 5'(DIV_STEPS - 1);
         busy_d = 1'b1;
      end else if (busy_q) begin
         rem_d = fits ? (shifted[31:0] - dvs_q) : shifted[31:0];
         quo_d = {quo_q[30:0], fits};
         if (cnt_q == 5'd0) busy_d = 1'b0;
         else               cnt_d  = cnt_q - 5'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quo_q  <= 32'd0;
         rem_q  <= 32'd0;
         dvs_q  <= 32'd0;
         cnt_q  <= 5'd0;
         busy_q <= 1'b0;
      end else begin
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign last_o      = busy_q && (cnt_q == 5'd0);
   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;

endmodule

// File: rtl/apu_nn_responder.sv
// APU responder: fixed-latency MUL/MULH/MAC pipeline plus a 33-cycle signed/unsigned DIV/REM,
// returning exactly one in-order rvalid per grant.
module apu_nn_responder
   import apu_nn_responder_pkg::*;
#(
   parameter int PIPE_REG = 2,
   parameter int WOP      = 3,
   parameter int NARGS    = 3,
   parameter int NDSFLAGS = 1,
   parameter int NUSFLAGS = 2
) (
   input  logic              clk,
   input  logic              rst,
   apu_nn_responder_if.slave apu,
   output div_state_e        state_o
);

   logic [NARGS*32-1:0] opnds;
   logic [WOP-1:0]      op;
   logic [NDSFLAGS-1:0] dflags;
   logic [31:0]         a, b, c;
   logic                sgn;

   assign opnds  = apu.operands;
   assign op     = apu.op;
   assign dflags = apu.flags_in;
   assign a      = opnds[31:0];
   assign b      = opnds[63:32];
   assign c      = opnds[95:64];
   assign sgn    = dflags[0];

   div_state_e  state_q, state_d;
   pipe_stage_t pipe_q [PIPE_REG];
   pipe_stage_t pipe_d [PIPE_REG];
   pipe_stage_t entry;
   logic        is_div, pipe_empty, gnt, div_start, div_last;
   logic        q_neg_q, q_neg_d, r_neg_q, r_neg_d, divz_q, divz_d, is_rem_q, is_rem_d;
   logic [31:0] quo, rem, div_res;
   logic [63:0] xa, xb, prod;
   logic        out_valid;
   logic [31:0] out_res;
   logic [1:0]  out_fl;

   assign is_div = (op == APU_OP_DIV) || (op == APU_OP_REM);

   always_comb begin
      pipe_empty = 1'b1;
      for (int i = 0; i < PIPE_REG; i++)
         if (pipe_q[i].valid) pipe_empty = 1'b0;
   end

   // A div may only start on a drained pipe so its result can never collide with a pipe result.
   assign gnt       = apu.req && !rst && (state_q == IDLE) && (!is_div || pipe_empty);
   assign div_start = gnt && is_div;

   // Sign-extending both operands makes the low 64 product bits the signed product for MULH.
   assign xa   = {{32{sgn & a[31]}}, a};
   assign xb   = {{32{sgn & b[31]}}, b};
   assign prod = xa * xb;

   always_comb begin
      entry        = '0;
      entry.valid  = gnt && !is_div;
      case (op)
         APU_OP_MUL:  entry.result = prod[31:0];
         APU_OP_MULH: entry.result = prod[63:32];
         APU_OP_MAC:  entry.result = prod[31:0] + c;
         APU_OP_DIV,
         APU_OP_REM:  entry.result = 32'd0;
         default:     entry.flags[FLAG_ILL] = 1'b1;
      endcase
   end

   always_comb begin
      pipe_d[0] = entry;
      for (int i = 1; i < PIPE_REG; i++) pipe_d[i] = pipe_q[i-1];
   end

   always_comb begin
      state_d  = state_q;
      q_neg_d  = q_neg_q;
      r_neg_d  = r_neg_q;
      divz_d   = divz_q;
      is_rem_d = is_rem_q;
      case (state_q)
         IDLE: begin
            if (div_start) begin
               state_d  = DIV_BUSY;
               q_neg_d  = (sgn & a[31]) ^ (sgn & b[31]);
               r_neg_d  = sgn & a[31];
               divz_d   = (b == 32'd0);
               is_rem_d = (op == APU_OP_REM);
            end
         end
         DIV_BUSY: if (div_last) state_d = DIV_DONE;
         DIV_DONE: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         divz_q   <= 1'b0;
         is_rem_q <= 1'b0;
         for (int i = 0; i < PIPE_REG; i++) pipe_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
         divz_q   <= divz_d;
         is_rem_q <= is_rem_d;
         for (int i = 0; i < PIPE_REG; i++) pipe_q[i] <= pipe_d[i];
      end
   end

   apu_nn_serdiv u_serdiv (
      .clk         (clk),
      .rst         (rst),
      .start_i     (div_start),
      .dividend_i  (mag32(a, sgn)),
      .divisor_i   (mag32(b, sgn)),
      .last_o      (div_last),
      .quotient_o  (quo),
      .remainder_o (rem)
   );

   // Divide-by-zero keeps the all-ones quotient regardless of the dividend sign.
   always_comb begin
      if (is_rem_q) div_res = r_neg_q ? (~rem + 32'd1) : rem;
      else          div_res = (q_neg_q && !divz_q) ? (~quo + 32'd1) : quo;
   end

   always_comb begin
      out_valid = 1'b0;
      out_res   = 32'd0;
      out_fl    = 2'b00;
      if (state_q == DIV_DONE) begin
         out_valid         = 1'b1;
         out_res           = div_res;
         out_fl[FLAG_DIVZ] = divz_q;
      end else if (pipe_q[PIPE_REG-1].valid) begin
         out_valid = 1'b1;
         out_res   = pipe_q[PIPE_REG-1].result;
         out_fl    = pipe_q[PIPE_REG-1].flags;
      end
   end

   assign apu.gnt       = gnt;
   assign apu.rvalid    = out_valid;
   assign apu.result    = out_res;
   assign apu.flags_out = NUSFLAGS'(out_fl);
   assign state_o       = state_q;

endmodule

// File: tb/tb_apu_nn_responder.sv
// Directed bench for apu_nn_responder: a vector table for single ops plus hand-written
// sequences for back-to-back issue, div stall behind the pipe, DIV_DONE gnt and mid-div reset.
module tb_apu_nn_responder;
   import apu_nn_responder_pkg::*;

   localparam int PIPE_REG = 2;
   localparam int DIV_LAT  = 33;

   logic       clk = 1'b0;
   logic       rst;
   div_state_e state;
   int         checks = 0;
   int         errors = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   apu_nn_responder_if bus ();

   apu_nn_responder #(.PIPE_REG(PIPE_REG)) dut (
      .clk     (clk),
      .rst     (rst),
      .apu     (bus),
      .state_o (state)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b, c;
      logic        sgn;
      logic [31:0] exp_res;
      logic [1:0]  exp_fl;
      int          exp_lat;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic sgn, input logic [31:0] r,
                               input logic [1:0] f);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.c = c; v.sgn = sgn;
      v.exp_res = r; v.exp_fl = f;
      v.exp_lat = (op == 3'd3 || op == 3'd4) ? DIV_LAT : PIPE_REG;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic sgn);
      bus.req      = 1'b1;
      bus.op       = op;
      bus.operands = {c, b, a};
      bus.flags_in = sgn;
   endtask

   // Called #1 after a rising edge with req asserted; returns #1 after the grant edge.
   task automatic wait_gnt(input string name);
      logic got;
      got = 1'b0;
      for (int w = 0; w < 60; w++) begin
         @(negedge clk);
         if (bus.gnt) begin got = 1'b1; break; end
      end
      check({name, " gnt"}, 32'(got), 32'd1);
      @(posedge clk); #1;
      bus.req = 1'b0;
   endtask

   // Called #1 after the grant edge; latency counts cycles after the grant cycle.
   task automatic wait_rsp(input string name, input logic [1:0] exp_fl, input int exp_lat);
      logic        got;
      int          lat;
      logic [31:0] res, exp;
      logic [1:0]  fl;
      got = 1'b0; lat = 0; res = '0; fl = '0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.rvalid) begin
            got = 1'b1; lat = k; res = bus.result; fl = bus.flags_out;
            break;
         end
      end
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check({name, " rvalid"}, 32'(got), 32'd1);
      check({name, " latency"}, 32'(lat), 32'(exp_lat));
      check({name, " result"}, res, exp);
      check({name, " flags"}, 32'(fl), 32'(exp_fl));
      @(posedge clk); #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rv_cnt, early_gnt;
      rst = 1'b1;
      bus.req = 1'b0; bus.op = '0; bus.operands = '0; bus.flags_in = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("reset rvalid", 32'(bus.rvalid), 32'd0);
      check("reset result", bus.result, 32'd0);
      check("reset flags", 32'(bus.flags_out), 32'd0);
      check("reset gnt", 32'(bus.gnt), 32'd0);
      check("reset state", 32'(state), 32'(IDLE));
      @(posedge clk); #1;
      rst = 1'b0;

      // Single-op vector table
      vecs.push_back(mk(3'd0, 32'd7, 32'd6, 32'd0, 1'b0, 32'd42, 2'b00));
      vecs.push_back(mk(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'hFFFF_FFFE, 2'b00));
      vecs.push_back(mk(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'h0000_0000, 2'b00));
      vecs.push_back(mk(3'd1, 32'hFFFF_FFFE, 32'd3, 32'd0, 1'b0, 32'h0000_0002, 2'b00));
      vecs.push_back(mk(3'd2, 32'd10, 32'd20, 32'd5, 1'b0, 32'd205, 2'b00));
      vecs.push_back(mk(3'd6, 32'd1, 32'd2, 32'd3, 1'b0, 32'd0, 2'b10));
      vecs.push_back(mk(3'd5, 32'd9, 32'd9, 32'd9, 1'b1, 32'd0, 2'b10));
      vecs.push_back(mk(3'd7, 32'd4, 32'd4, 32'd4, 1'b0, 32'd0, 2'b10));
      vecs.push_back(mk(3'd3, 32'd100, 32'd7, 32'd0, 1'b0, 32'd14, 2'b00));
      vecs.push_back(mk(3'd4, 32'd100, 32'd7, 32'd0, 1'b0, 32'd2, 2'b00));
      vecs.push_back(mk(3'd3, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b1, 32'hFFFF_FFFD, 2'b00));
      vecs.push_back(mk(3'd4, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b1, 32'hFFFF_FFFF, 2'b00));
      vecs.push_back(mk(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'h8000_0000, 2'b00));
      vecs.push_back(mk(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'h0000_0000, 2'b00));
      vecs.push_back(mk(3'd3, 32'd5, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF, 2'b01));
      vecs.push_back(mk(3'd4, 32'd5, 32'd0, 32'd0, 1'b0, 32'd5, 2'b01));
      vecs.push_back(mk(3'd3, 32'hFFFF_FFF9, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 2'b01));
      vecs.push_back(mk(3'd4, 32'hFFFF_FFF9, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFF9, 2'b01));
      vecs.push_back(mk(3'd3, 32'hFFFF_FFFF, 32'd16, 32'd0, 1'b0, 32'h0FFF_FFFF, 2'b00));
      vecs.push_back(mk(3'd3, 32'd7, 32'hFFFF_FFFE, 32'd0, 1'b1, 32'hFFFF_FFFD, 2'b00));
      vecs.push_back(mk(3'd4, 32'd7, 32'hFFFF_FFFE, 32'd0, 1'b1, 32'd1, 2'b00));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sgn);
         exp_q.push_back(vecs[i].exp_res);
         wait_gnt($sformatf("vec%0d", i));
         wait_rsp($sformatf("vec%0d", i), vecs[i].exp_fl, vecs[i].exp_lat);
      end

      // Back-to-back MAC then signed MULH: consecutive rvalids
      drive(3'd2, 32'hFFFF_FFFF, 32'd2, 32'd3, 1'b0);
      exp_q.push_back(32'h0000_0001);
      @(negedge clk);
      check("b2b gnt0", 32'(bus.gnt), 32'd1);
      @(posedge clk); #1;
      drive(3'd1, 32'hFFFF_FFFE, 32'd3, 32'd0, 1'b1);
      exp_q.push_back(32'hFFFF_FFFF);
      @(negedge clk);
      check("b2b gnt1", 32'(bus.gnt), 32'd1);
      @(posedge clk); #1;
      bus.req = 1'b0;
      @(negedge clk);
      check("b2b rvalid0", 32'(bus.rvalid), 32'd1);
      check("b2b result0", bus.result, exp_q.pop_front());
      @(negedge clk);
      check("b2b rvalid1", 32'(bus.rvalid), 32'd1);
      check("b2b result1", bus.result, exp_q.pop_front());
      @(negedge clk);
      check("b2b rvalid idle", 32'(bus.rvalid), 32'd0);
      check("b2b result idle", bus.result, 32'd0);
      @(posedge clk); #1;

      // MUL followed by DIV: DIV grant withheld until the pipe drains
      drive(3'd0, 32'd3, 32'd5, 32'd0, 1'b0);
      @(negedge clk);
      check("stall mul gnt", 32'(bus.gnt), 32'd1);
      @(posedge clk); #1;
      drive(3'd3, 32'd100, 32'd7, 32'd0, 1'b0);
      @(negedge clk);
      check("stall c1 gnt", 32'(bus.gnt), 32'd0);
      @(negedge clk);
      check("stall c2 gnt", 32'(bus.gnt), 32'd0);
      check("stall mul rvalid", 32'(bus.rvalid), 32'd1);
      check("stall mul result", bus.result, 32'd15);
      @(negedge clk);
      check("stall c3 gnt", 32'(bus.gnt), 32'd1);
      @(posedge clk); #1;
      bus.req = 1'b0;
      exp_q.push_back(32'd14);
      wait_rsp("stall div", 2'b00, DIV_LAT);

      // A request pending through a div is granted only in the IDLE cycle after DIV_DONE
      drive(3'd3, 32'd20, 32'd3, 32'd0, 1'b0);
      wait_gnt("done div");
      drive(3'd0, 32'd2, 32'd2, 32'd0, 1'b0);
      early_gnt = 0;
      rv_cnt    = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.gnt) early_gnt++;
         if (bus.rvalid) begin
            rv_cnt = k;
            check("done div result", bus.result, 32'd6);
            break;
         end
      end
      check("done div latency", 32'(rv_cnt), 32'(DIV_LAT));
      check("done gnt while busy", 32'(early_gnt), 32'd0);
      @(negedge clk);
      check("done gnt after", 32'(bus.gnt), 32'd1);
      @(posedge clk); #1;
      bus.req = 1'b0;
      exp_q.push_back(32'd4);
      wait_rsp("done mul", 2'b00, PIPE_REG);

      // Reset in the middle of a division aborts it
      drive(3'd3, 32'd100, 32'd7, 32'd0, 1'b0);
      wait_gnt("abort div");
      repeat (9) @(posedge clk);
      #1;
      check("abort busy before rst", 32'(state), 32'(DIV_BUSY));
      rst = 1'b1;
      @(negedge clk);
      check("abort rst state", 32'(state), 32'(IDLE));
      check("abort rst rvalid", 32'(bus.rvalid), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      drive(3'd0, 32'd9, 32'd9, 32'd0, 1'b0);
      @(negedge clk);
      check("abort mul gnt", 32'(bus.gnt), 32'd1);
      @(posedge clk); #1;
      bus.req = 1'b0;
      exp_q.push_back(32'd81);
      wait_rsp("abort mul", 2'b00, PIPE_REG);
      rv_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.rvalid) rv_cnt++;
      end
      check("abort no stray rvalid", 32'(rv_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
